seg_display_scheduler: RTL

Time-multiplexes several 32-bit hex values onto the single 8-digit seven-segment display on the Nexys4 DDR board. It rotates round-robin through the sources that currently have data, holding each for a fixed dwell time. A one-shot message request can pre-empt the rotation for a fixed time. The block sits between the application logic and SevenSegmentDisplayController; disp_value drives that controller's 32-bit value input.

---
 rtl/seg_sched_pkg.sv | 28 ++
 rtl/seg_rr_pick.sv | 41 ++++
 rtl/seg_display_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   sched_state_t : scheduler state encoding (IDLE, ROTATE, MSG)
//   BLANK_ALL     : blank mask with every digit off
//   BLANK_NONE    : blank mask with every digit lit
//   cnt_width()   : bit width needed for a counter that must reach
//                   max(a, b) - 1 without wrapping
package seg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        MSG    = 2'd2
    } sched_state_t;

    localparam logic [7:0] BLANK_ALL  = 8'hFF;
    localparam logic [7:0] BLANK_NONE = 8'h00;

    // Smallest width (at least 1) whose range covers 0 .. max(a, b) - 1.
    function automatic int cnt_width(input int a, input int b);
        longint m;
        int     w;
        m = (a > b) ? longint'(a) : longint'(b);
        w = 1;
        while ((longint'(1) << w) < m) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker.
// Finds the first valid index strictly after cur_idx, wrapping modulo
// NUM_SRC. If cur_idx is the only valid index it is returned itself; if
// nothing is valid, cur_idx is returned unchanged and any_valid is low.
// Passing cur_idx = NUM_SRC-1 yields the lowest valid index.
// Ports:
//   valid     in  NUM_SRC          per-source valid flags
//   cur_idx   in  $clog2(NUM_SRC)  search starts after this index
//   next_idx  out $clog2(NUM_SRC)  selected index
//   any_valid out 1                at least one valid flag is set
module seg_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         valid,
    input  logic [$clog2(NUM_SRC)-1:0] cur_idx,
    output logic [$clog2(NUM_SRC)-1:0] next_idx,
    output logic                       any_valid
);

    localparam int IW = $clog2(NUM_SRC);

    assign any_valid = |valid;

    // Scan offsets 1..NUM_SRC from cur_idx; the final offset lands back on
    // cur_idx, which covers the single-valid-source case.
    always_comb begin : pick_loop
        int   j;
        logic found;
        next_idx = cur_idx;
        found    = 1'b0;
        j        = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            j = (int'(cur_idx) + k) % NUM_SRC;
            if (!found && valid[j]) begin
                next_idx = IW'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexes several 32-bit hex values onto the 8-digit display.
// Rotates round-robin through the valid sources, each held for
// DWELL_CYCLES, and lets a one-shot message pre-empt the rotation for
// MSG_CYCLES. All outputs are registered and change on the same edge as
// the state / pointer they describe.
// Optional build macro: SEG_SCHED_BLINK_EN blinks the message display with
// half-period BLINK_HALF_CYCLES (first phase lit); without it the message
// is shown steady.
// Ports:
//   clk        in  1                system clock
//   reset      in  1                synchronous, active-high reset
//   src_data   in  32*NUM_SRC       source i at bits [32*i+31:32*i]
//   src_valid  in  NUM_SRC          source i has data to show
//   msg_req    in  1                message request level, held until acked
//   msg_data   in  32               message value, captured on the ack cycle
//   msg_ack    out 1                one-cycle pulse: message accepted
//   disp_value out 32               value for the display controller
//   disp_blank out 8                per-digit blank mask, 1 = digit off
//   cur_src    out $clog2(NUM_SRC)  index of the source being shown
//   msg_active out 1                high while a message is shown
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter int NUM_SRC           = 4,
    parameter int DWELL_CYCLES      = 100_000_000,
    parameter int MSG_CYCLES        = 300_000_000,
    parameter int BLINK_HALF_CYCLES = 25_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [32*NUM_SRC-1:0]      src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic                       msg_req,
    input  logic [31:0]                msg_data,
    output logic                       msg_ack,
    output logic [31:0]                disp_value,
    output logic [7:0]                 disp_blank,
    output logic [$clog2(NUM_SRC)-1:0] cur_src,
    output logic                       msg_active
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = cnt_width(DWELL_CYCLES, MSG_CYCLES);

    if (NUM_SRC < 2 || NUM_SRC > 8 || DWELL_CYCLES < 1 || MSG_CYCLES < 1 ||
        BLINK_HALF_CYCLES < 1) begin : g_param_check
        $error("seg_display_scheduler: parameter out of range");
    end

    sched_state_t  state, state_nxt;
    logic [IW-1:0] cur_nxt;
    logic [CW-1:0] dwell_cnt, dwell_nxt;
    logic [CW-1:0] msg_cnt, msg_nxt;
    logic          ack_nxt;
    logic [31:0]   value_nxt;
    logic [7:0]    blank_nxt;

    logic [IW-1:0] pick_base;
    logic [IW-1:0] pick_next;
    logic          any_valid;

    // From IDLE the search starts after the top index so the picker returns
    // the lowest valid source; otherwise it searches after cur_src.
    assign pick_base = (state == IDLE) ? IW'(NUM_SRC - 1) : cur_src;

    seg_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .valid     (src_valid),
        .cur_idx   (pick_base),
        .next_idx  (pick_next),
        .any_valid (any_valid)
    );

`ifdef SEG_SCHED_BLINK_EN
    localparam int BW = cnt_width(BLINK_HALF_CYCLES, 1);
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_on, blink_on_nxt;
`endif

    // Next-state logic. A message request pre-empts everything else in
    // IDLE and ROTATE (including a same-cycle dwell expiry, which then does
    // not advance cur_src). Requests are ignored while a message is shown.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_src;
        dwell_nxt = dwell_cnt;
        msg_nxt   = msg_cnt;
        ack_nxt   = 1'b0;
        value_nxt = disp_value;
        blank_nxt = disp_blank;
`ifdef SEG_SCHED_BLINK_EN
        blink_cnt_nxt = blink_cnt;
        blink_on_nxt  = blink_on;
`endif
        case (state)
            IDLE, ROTATE: begin
                if (msg_req) begin
                    state_nxt = MSG;
                    ack_nxt   = 1'b1;
                    msg_nxt   = '0;
                    dwell_nxt = '0;
                    value_nxt = msg_data;
`ifdef SEG_SCHED_BLINK_EN
                    blink_cnt_nxt = '0;
                    blink_on_nxt  = 1'b1;
`endif
                end else if (!any_valid) begin
                    state_nxt = IDLE;
                    dwell_nxt = '0;
                end else if (state == IDLE) begin
                    state_nxt = ROTATE;
                    cur_nxt   = pick_next;
                    dwell_nxt = '0;
                end else if (!src_valid[cur_src] ||
                             dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
                    cur_nxt   = pick_next;
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            MSG: begin
                if (msg_cnt == CW'(MSG_CYCLES - 1)) begin
                    msg_nxt   = '0;
                    dwell_nxt = '0;
                    if (any_valid) begin
                        state_nxt = ROTATE;
                        cur_nxt   = src_valid[cur_src] ? cur_src : pick_next;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    msg_nxt = msg_cnt + 1'b1;
`ifdef SEG_SCHED_BLINK_EN
                    if (blink_cnt == BW'(BLINK_HALF_CYCLES - 1)) begin
                        blink_cnt_nxt = '0;
                        blink_on_nxt  = !blink_on;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                cur_nxt   = '0;
                dwell_nxt = '0;
                msg_nxt   = '0;
            end
        endcase

        // Display outputs follow the state being entered so they line up
        // with cur_src and msg_active on the same edge.
        case (state_nxt)
            ROTATE: begin
                value_nxt = src_data[int'(cur_nxt)*32 +: 32];
                blank_nxt = BLANK_NONE;
            end
            MSG: begin
`ifdef SEG_SCHED_BLINK_EN
                blank_nxt = blink_on_nxt ? BLANK_NONE : BLANK_ALL;
`else
                blank_nxt = BLANK_NONE;
`endif
            end
            default: begin
                value_nxt = '0;
                blank_nxt = BLANK_ALL;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_src    <= '0;
            dwell_cnt  <= '0;
            msg_cnt    <= '0;
            msg_ack    <= 1'b0;
            msg_active <= 1'b0;
            disp_value <= '0;
            disp_blank <= BLANK_ALL;
        end else begin
            state      <= state_nxt;
            cur_src    <= cur_nxt;
            dwell_cnt  <= dwell_nxt;
            msg_cnt    <= msg_nxt;
            msg_ack    <= ack_nxt;
            msg_active <= (state_nxt == MSG);
            disp_value <= value_nxt;
            disp_blank <= blank_nxt;
        end
    end

`ifdef SEG_SCHED_BLINK_EN
    // Blink phase register, restarted with the first phase lit on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
        end
    end
`endif

endmodule
